// File: rtl/cu_pkg.sv
// cu_pkg: state, opcode and ALU encodings shared by the control_unit slice
package cu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_HALT} state_t;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_MOVR  = 4'h3;
  localparam logic [3:0] OP_MVAC  = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_INCAR = 4'h7;
  localparam logic [3:0] OP_LDAR  = 4'h8;
  localparam logic [3:0] OP_JMPZ  = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_MUL   = 4'hB;
  localparam logic [3:0] OP_PCAR  = 4'hC;
  localparam logic [3:0] OP_END   = 4'hF;
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_MUL  = 2'b11;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction/flag inputs and bus select/strobe outputs between sequencer and datapath
interface control_unit_if;
  logic [15:0] ir;
  logic z_flag;
  logic PC_read_en, AR_read_en, AC_read_en, R_read_en, IM_read_en, DM_read_en, DR_read_en;
  logic IR_write_en, PC_write_en, AR_write_en, AC_write_en, R_write_en, DR_write_en, DM_write_en;
  logic PC_inc, AR_inc;
  logic [1:0] alu_op;
  modport master (
    input ir, z_flag,
    output PC_read_en, AR_read_en, AC_read_en, R_read_en, IM_read_en, DM_read_en, DR_read_en,
    output IR_write_en, PC_write_en, AR_write_en, AC_write_en, R_write_en, DR_write_en, DM_write_en,
    output PC_inc, AR_inc, alu_op
  );
  modport slave (
    output ir, z_flag,
    input PC_read_en, AR_read_en, AC_read_en, R_read_en, IM_read_en, DM_read_en, DR_read_en,
    input IR_write_en, PC_write_en, AR_write_en, AC_write_en, R_write_en, DR_write_en, DM_write_en,
    input PC_inc, AR_inc, alu_op
  );
endinterface

// File: rtl/cu_decoder.sv
// cu_decoder: opcode classification (two-cycle, END, legal); CU_MUL_EN makes opcode B a legal two-cycle MUL
module cu_decoder
  import cu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_two_cycle,
  output logic       is_end,
  output logic       legal
);
  assign is_end = opcode == OP_END;
`ifdef CU_MUL_EN
  assign is_two_cycle = opcode == OP_LOAD || opcode == OP_MUL;
  assign legal = opcode <= OP_PCAR || is_end;
`else
  assign is_two_cycle = opcode == OP_LOAD;
  assign legal = (opcode <= OP_PCAR && opcode != OP_MUL) || is_end;
`endif
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving one bus source per cycle; define CU_MUL_EN for opcode B MUL
module control_unit
  import cu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  control_unit_if.master   bus,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  state_t state, state_nx;
  logic [3:0] op, exec_op;
  logic two, is_end, legal;
  assign op = bus.ir[15:12];
  cu_decoder u_dec (.opcode(op), .is_two_cycle(two), .is_end(is_end), .legal(legal));
  // undefined opcodes fall through to the NOP row of the execute decode
  assign exec_op = legal ? op : OP_NOP;
  assign halted = state == S_HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) instr_count <= instr_count + 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = start ? S_FETCH : S_IDLE;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = is_end ? S_HALT : S_EXEC1;
      S_EXEC1:  state_nx = two ? S_EXEC2 : S_FETCH;
      S_EXEC2:  state_nx = S_FETCH;
      default:  state_nx = state;
    endcase
  end
  always_comb begin
    bus.PC_read_en = 1'b0;
    bus.AR_read_en = 1'b0;
    bus.AC_read_en = 1'b0;
    bus.R_read_en = 1'b0;
    bus.IM_read_en = 1'b0;
    bus.DM_read_en = 1'b0;
    bus.DR_read_en = 1'b0;
    bus.IR_write_en = 1'b0;
    bus.PC_write_en = 1'b0;
    bus.AR_write_en = 1'b0;
    bus.AC_write_en = 1'b0;
    bus.R_write_en = 1'b0;
    bus.DR_write_en = 1'b0;
    bus.DM_write_en = 1'b0;
    bus.PC_inc = 1'b0;
    bus.AR_inc = 1'b0;
    bus.alu_op = ALU_PASS;
    case (state)
      S_FETCH: begin
        bus.IM_read_en = 1'b1;
        bus.IR_write_en = 1'b1;
        bus.PC_inc = 1'b1;
      end
      S_EXEC1: begin
        case (exec_op)
          OP_LOAD:  begin bus.DM_read_en = 1'b1; bus.DR_write_en = 1'b1; end
          OP_STORE: begin bus.AC_read_en = 1'b1; bus.DM_write_en = 1'b1; end
          OP_MOVR:  begin bus.AC_read_en = 1'b1; bus.R_write_en = 1'b1; end
          OP_MVAC:  begin bus.R_read_en = 1'b1; bus.AC_write_en = 1'b1; end
          OP_ADD:   begin bus.R_read_en = 1'b1; bus.alu_op = ALU_ADD; bus.AC_write_en = 1'b1; end
          OP_SUB:   begin bus.R_read_en = 1'b1; bus.alu_op = ALU_SUB; bus.AC_write_en = 1'b1; end
          OP_INCAR: bus.AR_inc = 1'b1;
          OP_LDAR:  begin bus.AC_read_en = 1'b1; bus.AR_write_en = 1'b1; end
          OP_JMPZ:  begin bus.AC_read_en = 1'b1; bus.PC_write_en = bus.z_flag; end
          OP_JMP:   begin bus.AC_read_en = 1'b1; bus.PC_write_en = 1'b1; end
          OP_PCAR:  begin bus.PC_read_en = 1'b1; bus.AR_write_en = 1'b1; end
`ifdef CU_MUL_EN
          OP_MUL:   begin bus.R_read_en = 1'b1; bus.alu_op = ALU_MUL; end
`endif
          default: ;
        endcase
      end
      S_EXEC2: begin
        bus.AC_write_en = 1'b1;
        if (op == OP_LOAD) bus.DR_read_en = 1'b1;
`ifdef CU_MUL_EN
        else begin
          bus.R_read_en = 1'b1;
          bus.alu_op = ALU_MUL;
        end
`endif
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table, multi-cycle corner sequences and a random instruction-stream scoreboard
module tb_control_unit;
  localparam int TB_CNT_W = 10;
  localparam logic [6:0] NONE = 7'b0;
  localparam logic [6:0] RD_PC = 7'b1000000, RD_AR = 7'b0100000, RD_AC = 7'b0010000, RD_R = 7'b0001000;
  localparam logic [6:0] RD_IM = 7'b0000100, RD_DM = 7'b0000010, RD_DR = 7'b0000001;
  localparam logic [6:0] WR_IR = 7'b1000000, WR_PC = 7'b0100000, WR_AR = 7'b0010000, WR_AC = 7'b0001000;
  localparam logic [6:0] WR_R = 7'b0000100, WR_DR = 7'b0000010, WR_DM = 7'b0000001;
  localparam logic [1:0] A_PASS = 2'b00, A_ADD = 2'b01, A_SUB = 2'b10, A_MUL = 2'b11;
  typedef struct packed {
    logic [6:0] rd;
    logic [6:0] wr;
    logic       pc_inc;
    logic       ar_inc;
    logic [1:0] alu;
    logic       halted;
  } outs_t;
  typedef struct {
    logic [3:0] op;
    logic       z;
    int         ncyc;
    outs_t      e1;
    outs_t      e2;
  } vec_t;
  typedef struct {
    outs_t      o;
    logic       zdep;
    logic       fetch;
    logic       endd;
    logic [3:0] op;
  } el_t;
  logic clk = 1'b0;
  logic rst, start, halted;
  logic [TB_CNT_W-1:0] instr_count;
  int checks = 0, failures = 0;
  control_unit_if bus ();
  control_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master), .halted(halted), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  function automatic outs_t ov(input logic [6:0] rd, input logic [6:0] wr, input logic pci, input logic ari,
                               input logic [1:0] alu, input logic h);
    outs_t o;
    o.rd = rd;
    o.wr = wr;
    o.pc_inc = pci;
    o.ar_inc = ari;
    o.alu = alu;
    o.halted = h;
    return o;
  endfunction
  function automatic outs_t sample();
    outs_t o;
    o.rd = {bus.PC_read_en, bus.AR_read_en, bus.AC_read_en, bus.R_read_en, bus.IM_read_en, bus.DM_read_en, bus.DR_read_en};
    o.wr = {bus.IR_write_en, bus.PC_write_en, bus.AR_write_en, bus.AC_write_en, bus.R_write_en, bus.DR_write_en, bus.DM_write_en};
    o.pc_inc = bus.PC_inc;
    o.ar_inc = bus.AR_inc;
    o.alu = bus.alu_op;
    o.halted = halted;
    return o;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  outs_t fetch_v, halt_v;
  vec_t tbl[$];
  el_t q[$];
  logic [TB_CNT_W-1:0] cnt_exp;
  logic idle_m, halted_m;
  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    chk($sformatf("vec%0d_fetch", i), 32'(sample()), 32'(fetch_v));
    bus.ir = {v.op, 12'h5A5};
    bus.z_flag = v.z;
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_decode", i), 32'(sample()), 32'(0));
    chk($sformatf("vec%0d_count", i), 32'(instr_count), 32'(i + 1));
    @(negedge clk);
    chk($sformatf("vec%0d_e1", i), 32'(sample()), 32'(v.e1));
    if (v.ncyc == 4) begin
      @(negedge clk);
      chk($sformatf("vec%0d_e2", i), 32'(sample()), 32'(v.e2));
    end
  endtask
  task automatic push_ex(input outs_t o, input logic zd);
    q.push_back('{o: o, zdep: zd, fetch: 1'b0, endd: 1'b0, op: 4'h0});
  endtask
  // one instruction becomes its list of per-cycle bus actions
  task automatic push_instr(input logic [3:0] op);
    q.push_back('{o: fetch_v, zdep: 1'b0, fetch: 1'b1, endd: 1'b0, op: op});
    q.push_back('{o: '0, zdep: 1'b0, fetch: 1'b0, endd: (op == 4'hF), op: op});
    case (op)
      4'h1: begin
        push_ex(ov(RD_DM, WR_DR, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
        push_ex(ov(RD_DR, WR_AC, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
      end
      4'h2: push_ex(ov(RD_AC, WR_DM, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
      4'h3: push_ex(ov(RD_AC, WR_R, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
      4'h4: push_ex(ov(RD_R, WR_AC, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
      4'h5: push_ex(ov(RD_R, WR_AC, 1'b0, 1'b0, A_ADD, 1'b0), 1'b0);
      4'h6: push_ex(ov(RD_R, WR_AC, 1'b0, 1'b0, A_SUB, 1'b0), 1'b0);
      4'h7: push_ex(ov(NONE, NONE, 1'b0, 1'b1, A_PASS, 1'b0), 1'b0);
      4'h8: push_ex(ov(RD_AC, WR_AR, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
      4'h9: push_ex(ov(RD_AC, NONE, 1'b0, 1'b0, A_PASS, 1'b0), 1'b1);
      4'hA: push_ex(ov(RD_AC, WR_PC, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
      4'hC: push_ex(ov(RD_PC, WR_AR, 1'b0, 1'b0, A_PASS, 1'b0), 1'b0);
`ifdef CU_MUL_EN
      4'hB: begin
        push_ex(ov(RD_R, NONE, 1'b0, 1'b0, A_MUL, 1'b0), 1'b0);
        push_ex(ov(RD_R, WR_AC, 1'b0, 1'b0, A_MUL, 1'b0), 1'b0);
      end
`endif
      4'hF: ;
      default: push_ex('0, 1'b0);
    endcase
  endtask
  initial begin
    fetch_v = ov(RD_IM, WR_IR, 1'b1, 1'b0, A_PASS, 1'b0);
    halt_v = ov(NONE, NONE, 1'b0, 1'b0, A_PASS, 1'b1);
    tbl.push_back('{op: 4'h5, z: 1'b0, ncyc: 3, e1: ov(RD_R, WR_AC, 1'b0, 1'b0, A_ADD, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h1, z: 1'b0, ncyc: 4, e1: ov(RD_DM, WR_DR, 1'b0, 1'b0, A_PASS, 1'b0),
                    e2: ov(RD_DR, WR_AC, 1'b0, 1'b0, A_PASS, 1'b0)});
    tbl.push_back('{op: 4'h9, z: 1'b0, ncyc: 3, e1: ov(RD_AC, NONE, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h9, z: 1'b1, ncyc: 3, e1: ov(RD_AC, WR_PC, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h0, z: 1'b1, ncyc: 3, e1: '0, e2: '0});
    tbl.push_back('{op: 4'h2, z: 1'b0, ncyc: 3, e1: ov(RD_AC, WR_DM, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h3, z: 1'b0, ncyc: 3, e1: ov(RD_AC, WR_R, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h4, z: 1'b0, ncyc: 3, e1: ov(RD_R, WR_AC, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h6, z: 1'b1, ncyc: 3, e1: ov(RD_R, WR_AC, 1'b0, 1'b0, A_SUB, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h7, z: 1'b0, ncyc: 3, e1: ov(NONE, NONE, 1'b0, 1'b1, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'h8, z: 1'b0, ncyc: 3, e1: ov(RD_AC, WR_AR, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'hA, z: 1'b0, ncyc: 3, e1: ov(RD_AC, WR_PC, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
    tbl.push_back('{op: 4'hC, z: 1'b1, ncyc: 3, e1: ov(RD_PC, WR_AR, 1'b0, 1'b0, A_PASS, 1'b0), e2: '0});
`ifdef CU_MUL_EN
    tbl.push_back('{op: 4'hB, z: 1'b0, ncyc: 4, e1: ov(RD_R, NONE, 1'b0, 1'b0, A_MUL, 1'b0),
                    e2: ov(RD_R, WR_AC, 1'b0, 1'b0, A_MUL, 1'b0)});
`else
    tbl.push_back('{op: 4'hB, z: 1'b0, ncyc: 3, e1: '0, e2: '0});
`endif
    tbl.push_back('{op: 4'hD, z: 1'b1, ncyc: 3, e1: '0, e2: '0});
    tbl.push_back('{op: 4'hE, z: 1'b0, ncyc: 3, e1: '0, e2: '0});
    tbl.push_back('{op: 4'hF, z: 1'b0, ncyc: 2, e1: halt_v, e2: '0});
    rst = 1'b1;
    start = 1'b0;
    bus.ir = 16'h0000;
    bus.z_flag = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(sample()), 32'(0));
    chk("reset_count", 32'(instr_count), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", 32'(sample()), 32'(0));
    start = 1'b1;
    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom);
      @(negedge clk);
      chk($sformatf("halt_hold%0d", i), 32'(sample()), 32'(halt_v));
      chk($sformatf("halt_count%0d", i), 32'(instr_count), 32'(tbl.size()));
    end
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("halt_rst_outs", 32'(sample()), 32'(0));
    chk("halt_rst_count", 32'(instr_count), 32'(0));
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_fetch", 32'(sample()), 32'(fetch_v));
    bus.ir = 16'h1000;
    start = 1'b0;
    @(negedge clk);
    chk("abort_decode", 32'(sample()), 32'(0));
    @(negedge clk);
    chk("abort_load_e1", 32'(sample()), 32'(ov(RD_DM, WR_DR, 1'b0, 1'b0, A_PASS, 1'b0)));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_outs", 32'(sample()), 32'(0));
    chk("abort_rst_count", 32'(instr_count), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(sample()), 32'(0));
    start = 1'b1;
    cnt_exp = '0;
    idle_m = 1'b0;
    halted_m = 1'b0;
    begin
      int hcnt;
      hcnt = 0;
      // no resets or END in the first half so instr_count wraps at least once
      for (int c = 0; c < 10000; c++) begin
        outs_t exp_o, act_o;
        el_t e;
        logic [3:0] op;
        @(negedge clk);
        if (!halted_m && !idle_m && q.size() == 0) begin
          op = 4'($urandom_range(0, 15));
          if (op == 4'hF && (c < 5000 || $urandom_range(0, 3) != 0)) op = 4'h0;
          push_instr(op);
        end
        exp_o = halted_m ? halt_v : (q.size() == 0 ? outs_t'(0) : q[0].o);
        if (q.size() != 0 && q[0].zdep && bus.z_flag) exp_o.wr = exp_o.wr | WR_PC;
        act_o = sample();
        chk($sformatf("rand_outs@%0d", c), 32'(act_o), 32'(exp_o));
        chk($sformatf("rand_count@%0d", c), 32'(instr_count), 32'(cnt_exp));
        chk($sformatf("rand_onehot@%0d", c), 32'($countones(act_o.rd) <= 1), 32'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          if (e.fetch) begin
            bus.ir = {e.op, 12'($urandom)};
            cnt_exp = cnt_exp + 1'b1;
          end
          if (e.endd) halted_m = 1'b1;
        end
        hcnt = halted_m ? hcnt + 1 : 0;
        if (rst) begin
          rst = 1'b0;
          idle_m = 1'b0;
        end else if (c > 5000 && (hcnt >= 5 || $urandom_range(0, 299) == 0)) begin
          rst = 1'b1;
          q.delete();
          idle_m = 1'b1;
          halted_m = 1'b0;
          cnt_exp = '0;
        end
        bus.z_flag = 1'($urandom);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
